gate_sweep_checker: RTL and testbench

- Stimulus-and-check stage wrapped around the combinational two-input gate block.
- Drives the block's a/b inputs through all four input combinations and holds each one for a programmable settle time.
- After each settle time, samples the block's seven gate outputs and compares them against a golden truth table.
- Reports a pass/fail verdict, a saturating mismatch count and a per-vector failure mask.

---
 rtl/gate_pkg.sv | 28 ++
 rtl/gate_golden.sv | 19 +
 rtl/gate_sweep_checker.sv | 109 ++++++++++
 tb/tb_gate_sweep_checker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared state encoding, golden vectors and gate_out bit map
package gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int GATE_W = 7;

  // Bit positions inside gate_out
  localparam int BIT_NOT_A = 0;
  localparam int BIT_OR    = 1;
  localparam int BIT_AND   = 2;
  localparam int BIT_XOR   = 3;
  localparam int BIT_NOR   = 4;
  localparam int BIT_NAND  = 5;
  localparam int BIT_XNOR  = 6;

  // Expected gate_out for each {a,b}
  localparam logic [GATE_W-1:0] GOLD_00 = 7'h71;
  localparam logic [GATE_W-1:0] GOLD_01 = 7'h2B;
  localparam logic [GATE_W-1:0] GOLD_10 = 7'h2A;
  localparam logic [GATE_W-1:0] GOLD_11 = 7'h46;

endpackage

// File: rtl/gate_golden.sv
// rtl/gate_golden.sv - golden truth-table lookup for the two-input gate block
module gate_golden
  import gate_pkg::*;
(
  input  logic [1:0]        index,
  output logic [GATE_W-1:0] expected
);

  // Map the {a,b} vector index to its reference gate outputs
  always_comb begin
    case (index)
      2'd0:    expected = GOLD_00;
      2'd1:    expected = GOLD_01;
      2'd2:    expected = GOLD_10;
      default: expected = GOLD_11;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - sweeps {a,b} through all vectors and checks gate_out
module gate_sweep_checker
  import gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              a,
  output logic              b,
  input  logic [GATE_W-1:0] gate_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [3:0]        fail_vec
);

  // Counter only has to reach SETTLE_CYCLES-1; keep at least one bit
  localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  state_t            state;
  logic [1:0]        index;
  logic [CNT_W-1:0]  settle_cnt;
  logic [GATE_W-1:0] expected;
  logic              mismatch;
  logic [ERR_W-1:0]  err_next;

  gate_golden u_golden (
    .index    (index),
    .expected (expected)
  );

  // Mismatch detect and saturating increment of the error count
  always_comb begin
    mismatch = (gate_out != expected);
    err_next = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + ERR_W'(1);
    end
  end

  // Sweep FSM: settle each vector, sample once, report at the end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      index      <= 2'd0;
      settle_cnt <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= ST_SETTLE;
            index      <= 2'd0;
            settle_cnt <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= 4'b0000;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == CNT_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          err_count <= err_next;
          if (mismatch) begin
            fail_vec[index] <= 1'b1;
          end
          if (index != 2'd3) begin
            index      <= index + 2'd1;
            {a, b}     <= index + 2'd1;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end else begin
            // pass must already reflect this final sample
            state <= ST_DONE;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            busy  <= 1'b0;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - scoreboard bench for gate_sweep_checker
module tb_gate_sweep_checker;

  localparam int S0 = 4;
  localparam int S1 = 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start   [2];
  logic       a_s     [2];
  logic       b_s     [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       pass_s  [2];
  logic [3:0] fv_s    [2];
  logic [7:0] err0;
  logic [0:0] err1;
  logic [6:0] fmask   [2][4];
  logic [6:0] gout0;
  logic [6:0] gout1;

  typedef struct {
    int done_cyc;
    int err;
    int fv;
    int pass;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t last_exp [2];
  bit   last_ok  [2];
  int   cyc = 0;
  int   free_at [2];
  int   acc     [2];
  bit   active  [2];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [6:0] truth(input logic x, input logic y);
    return {~(x ^ y), ~(x & y), ~(x | y), x ^ y, x & y, x | y, ~x};
  endfunction

  function automatic int settle(input int k);
    return (k == 0) ? S0 : S1;
  endfunction

  function automatic int emax(input int k);
    return (k == 0) ? 255 : 1;
  endfunction

  function automatic int err_of(input int k);
    return (k == 0) ? int'(err0) : int'(err1);
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  assign gout0 = truth(a_s[0], b_s[0]) ^ fmask[0][{a_s[0], b_s[0]}];
  assign gout1 = truth(a_s[1], b_s[1]) ^ fmask[1][{a_s[1], b_s[1]}];

  gate_sweep_checker #(.SETTLE_CYCLES(S0), .ERR_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a_s[0]), .b(b_s[0]),
    .gate_out(gout0), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .err_count(err0), .fail_vec(fv_s[0])
  );

  gate_sweep_checker #(.SETTLE_CYCLES(S1), .ERR_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a_s[1]), .b(b_s[1]),
    .gate_out(gout1), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .err_count(err1), .fail_vec(fv_s[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Drive start for ncyc cycles; every accept predicted by the model pushes an expectation
  task automatic issue(input int k, input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      start[k] = 1'b1;
      if (cyc + 1 >= free_at[k]) begin
        exp_t e;
        int   cnt;
        cnt  = 0;
        e.fv = 0;
        for (int i = 0; i < 4; i++) begin
          if (fmask[k][i] != 7'd0) begin
            cnt++;
            e.fv = e.fv | (1 << i);
          end
        end
        e.err      = (cnt > emax(k)) ? emax(k) : cnt;
        e.pass     = (cnt == 0) ? 1 : 0;
        e.done_cyc = cyc + 1 + 4 * (settle(k) + 1);
        free_at[k] = e.done_cyc + 2;
        acc[k]     = cyc + 1;
        active[k]  = 1'b1;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while ((cyc < free_at[k] || qsize(k) != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      chk("wait_idle_timeout", 1, 0);
      if (k == 0) q0.delete();
      else        q1.delete();
    end
    repeat (2) @(negedge clk);
    if (last_ok[k]) begin
      chk("hold_err", err_of(k), last_exp[k].err);
      chk("hold_fail_vec", int'(fv_s[k]), last_exp[k].fv);
      chk("hold_pass", int'(pass_s[k]), last_exp[k].pass);
    end
  endtask

  task automatic check_zero(input int k);
    chk("rst_a", int'(a_s[k]), 0);
    chk("rst_b", int'(b_s[k]), 0);
    chk("rst_busy", int'(busy_s[k]), 0);
    chk("rst_done", int'(done_s[k]), 0);
    chk("rst_pass", int'(pass_s[k]), 0);
    chk("rst_err", err_of(k), 0);
    chk("rst_fail_vec", int'(fv_s[k]), 0);
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      free_at[k] = 0;
      active[k]  = 1'b0;
      last_ok[k] = 1'b0;
    end
  endtask

  task automatic mon(input int k);
    int   j;
    exp_t e;
    if (active[k]) begin
      j = cyc - acc[k];
      if (j >= 0 && j < 4 * (settle(k) + 1)) begin
        chk("busy_during_sweep", int'(busy_s[k]), 1);
        chk("ab_vector", int'({a_s[k], b_s[k]}), j / (settle(k) + 1));
      end else if (j >= 4 * (settle(k) + 1)) begin
        active[k] = 1'b0;
      end
    end
    if (done_s[k]) begin
      if (qsize(k) == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("err_count", err_of(k), e.err);
        chk("fail_vec", int'(fv_s[k]), e.fv);
        chk("pass", int'(pass_s[k]), e.pass);
        chk("busy_at_done", int'(busy_s[k]), 0);
        last_exp[k] = e;
        last_ok[k]  = 1'b1;
      end
    end
  endtask

  // Monitor: compares whatever the DUTs present against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 2; k++) mon(k);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      for (int i = 0; i < 4; i++) fmask[k][i] = 7'd0;
    end
    clear_model();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero(0);
    check_zero(1);
    rst_n = 1'b1;

    // Clean sweep
    issue(0, 1);
    wait_idle(0);

    // XOR output stuck at 0, then fault removed
    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v = 2'(i);
      fmask[0][i] = truth(v[1], v[0]) & 7'h08;
    end
    issue(0, 1);
    wait_idle(0);
    for (int i = 0; i < 4; i++) fmask[0][i] = 7'd0;
    issue(0, 1);
    wait_idle(0);

    // start held high for 50 cycles
    issue(0, 50);
    wait_idle(0);

    // Reset in the middle of a sweep
    fmask[0][2] = 7'h10;
    issue(0, 1);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero(0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fmask[0][2] = 7'd0;
    issue(0, 1);
    wait_idle(0);

    // Random fault patterns with start pokes while busy
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) begin
        fmask[0][i] = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      end
      issue(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 14)) @(negedge clk);
        issue(0, 1);
      end
      wait_idle(0);
    end

    // Short settle, 1-bit counter, inverted gate block
    for (int i = 0; i < 4; i++) fmask[1][i] = 7'h7F;
    issue(1, 1);
    wait_idle(1);
    for (int i = 0; i < 4; i++) fmask[1][i] = 7'd0;
    issue(1, 1);
    wait_idle(1);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) begin
        fmask[1][i] = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      end
      issue(1, $urandom_range(1, 3));
      wait_idle(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
